// File: rtl/dds_pkg.sv
// dds_pkg: shared widths, saturation limit and FSM state encoding for the skew shaper.
package dds_pkg;
  localparam int W_DDS = 18;
  localparam int SLOPE_SHIFT = 9;
  localparam logic [W_DDS-1:0] DDS_MAX = 18'h3FFFF;
  typedef enum logic [1:0] {SEL = 2'd0, MUL = 2'd1, WR = 2'd2} state_t;
  function automatic logic [W_DDS-1:0] saturate(input logic [27:0] r);
    return (|r[27:W_DDS]) ? DDS_MAX : r[W_DDS-1:0];
  endfunction
endpackage

// File: rtl/dds_shaper_mult.sv
// dds_shaper_mult: registered 19x18 unsigned multiply, sized for a single DSP block.
module dds_shaper_mult (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [18:0] a,
  input  logic [17:0] b,
  output logic [36:0] p
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) p <= '0;
    else p <= a * b;
endmodule

// File: rtl/dds_skew_shaper.sv
// dds_skew_shaper: round-robin skewed-triangle shaper, one shared multiplier, 3 cycles/channel.
// Build option DDS_SHAPER_ROUND_EN selects round-half-up instead of truncation in the WR step.
module dds_skew_shaper
  import dds_pkg::*;
#(
  parameter int n = 12
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic [W_DDS*n-1:0] Phase,
  input  logic [W_DDS*n-1:0] Y1,
  input  logic [W_DDS*n-1:0] Y2,
  input  logic [W_DDS*n-1:0] Y3,
  output logic [W_DDS*n-1:0] Wave,
  output logic               Sweep
);
  localparam int CW = n > 1 ? $clog2(n) : 1;
  state_t state;
  logic [CW-1:0] ch;
  logic [W_DDS-1:0] ph, y1, y2, y3;
  logic rise;
  logic [18:0] mult_a;
  logic [17:0] mult_b;
  logic [36:0] prod;
  logic [27:0] r;
  assign ph = Phase[W_DDS*int'(ch) +: W_DDS];
  assign y1 = Y1[W_DDS*int'(ch) +: W_DDS];
  assign y2 = Y2[W_DDS*int'(ch) +: W_DDS];
  assign y3 = Y3[W_DDS*int'(ch) +: W_DDS];
  assign rise = ph < y1;
`ifdef DDS_SHAPER_ROUND_EN
  assign r = 28'((38'(prod) + 38'd256) >> SLOPE_SHIFT);
`else
  assign r = 28'(prod >> SLOPE_SHIFT);
`endif
  dds_shaper_mult u_mult (.clk(Clk), .rst_n(nReset), .a(mult_a), .b(mult_b), .p(prod));
  always_ff @(posedge Clk or negedge nReset)
    if (!nReset) begin
      state  <= SEL;
      ch     <= '0;
      mult_a <= '0;
      mult_b <= '0;
      Wave   <= '0;
      Sweep  <= 1'b0;
    end else begin
      Sweep <= 1'b0;
      case (state)
        SEL: begin
          mult_a <= rise ? {1'b0, ph} : 19'h40000 - {1'b0, ph};
          mult_b <= rise ? y2 : y3;
          state  <= MUL;
        end
        MUL: state <= WR;
        WR: begin
          Wave[W_DDS*int'(ch) +: W_DDS] <= saturate(r);
          ch    <= (ch == CW'(n - 1)) ? '0 : ch + 1'b1;
          Sweep <= ch == CW'(n - 1);
          state <= SEL;
        end
        default: state <= SEL;
      endcase
    end
endmodule

// File: tb/tb_dds_skew_shaper.sv
// tb_dds_skew_shaper: directed checks of reset, shaping, saturation, rounding, latency and mid-sweep reset.
module tb_dds_skew_shaper;
  localparam int N = 12;
`ifdef DDS_SHAPER_ROUND_EN
  localparam logic [17:0] E4 = 18'h00001, E10 = 18'h00002;
`else
  localparam logic [17:0] E4 = 18'h00000, E10 = 18'h00001;
`endif
  logic Clk = 1'b0;
  logic nReset = 1'b0;
  logic [18*N-1:0] Phase = '0, Y1 = '0, Y2 = '0, Y3 = '0;
  logic [18*N-1:0] Wave;
  logic Sweep;
  int compared = 0, mismatched = 0;
  logic [17:0] tp[N], ty1[N], ty2[N], ty3[N], te[N];

  dds_skew_shaper #(.n(N)) dut (
    .Clk(Clk), .nReset(nReset), .Phase(Phase), .Y1(Y1), .Y2(Y2), .Y3(Y3),
    .Wave(Wave), .Sweep(Sweep)
  );

  always #5 Clk = ~Clk;

  task automatic set_ch(input int c, input logic [17:0] p, y1, y2, y3);
    Phase[c*18 +: 18] = p;
    Y1[c*18 +: 18] = y1;
    Y2[c*18 +: 18] = y2;
    Y3[c*18 +: 18] = y3;
  endtask

  task automatic cycles_to_sweep(output int cnt);
    cnt = 0;
    do begin
      @(posedge Clk);
      @(negedge Clk);
      cnt++;
    end while (!Sweep && cnt < 200);
  endtask

  task automatic test_reset;
    int cnt;
    repeat (3) @(negedge Clk);
    compared++;
    if (Wave !== '0) begin mismatched++; $display("FAIL reset_wave got=%h want=0", Wave); end
    compared++;
    if (Sweep !== 1'b0) begin mismatched++; $display("FAIL reset_sweep got=%b want=0", Sweep); end
    nReset = 1'b1;
    cycles_to_sweep(cnt);
    compared++;
    if (cnt != 36) begin mismatched++; $display("FAIL first_sweep got=%0d want=36", cnt); end
    @(negedge Clk);
    compared++;
    if (Sweep !== 1'b0) begin mismatched++; $display("FAIL sweep_width got=%b want=0", Sweep); end
    cycles_to_sweep(cnt);
    compared++;
    if (cnt != 35) begin mismatched++; $display("FAIL sweep_period got=%0d want=36", cnt + 1); end
  endtask

  task automatic test_shape;
    int cnt;
    tp  = '{18'h08000, 18'h20000, 18'h10000, 18'h20000, 18'h00100, 18'h00000,
            18'h05000, 18'h3FFFF, 18'h0FFFF, 18'h30000, 18'h00155, 18'h00004};
    ty1 = '{18'h10000, 18'h3FFFF, 18'h10000, 18'h10000, 18'h10000, 18'h10000,
            18'h10000, 18'h00001, 18'h10000, 18'h20000, 18'h10000, 18'h00004};
    ty2 = '{18'h007FF, 18'h3FFFF, 18'h007FF, 18'h007FF, 18'h00001, 18'h007FF,
            18'h00000, 18'h3FFFF, 18'h007FF, 18'h003FF, 18'h00003, 18'h00000};
    ty3 = '{18'h002AA, 18'h3FFFF, 18'h002AA, 18'h002AA, 18'h002AA, 18'h002AA,
            18'h00000, 18'h00200, 18'h002AA, 18'h003FF, 18'h002AA, 18'h00200};
    te  = '{18'h1FFC0, 18'h3FFFF, 18'h3FF00, 18'h2AA00, E4, 18'h00000,
            18'h00000, 18'h00001, 18'h3FF7C, 18'h1FF80, E10, 18'h3FFFC};
    for (int c = 0; c < N; c++) set_ch(c, tp[c], ty1[c], ty2[c], ty3[c]);
    cycles_to_sweep(cnt);
    cycles_to_sweep(cnt);
    for (int c = 0; c < N; c++) begin
      compared++;
      if (Wave[c*18 +: 18] !== te[c]) begin
        mismatched++;
        $display("FAIL shape_ch%0d got=%h want=%h", c, Wave[c*18 +: 18], te[c]);
      end
    end
  endtask

  task automatic test_latency;
    int cnt;
    cycles_to_sweep(cnt);
    set_ch(0, 18'h04000, 18'h10000, 18'h007FF, 18'h002AA);
    repeat (2) begin
      @(posedge Clk);
      @(negedge Clk);
      compared++;
      if (Wave[17:0] !== 18'h1FFC0) begin mismatched++; $display("FAIL latency_early got=%h want=1ffc0", Wave[17:0]); end
    end
    @(posedge Clk);
    @(negedge Clk);
    compared++;
    if (Wave[17:0] !== 18'h0FFE0) begin mismatched++; $display("FAIL latency_update got=%h want=0ffe0", Wave[17:0]); end
  endtask

  task automatic test_reset_mid;
    int cnt;
    cycles_to_sweep(cnt);
    repeat (16) @(negedge Clk);
    nReset = 1'b0;
    #1;
    compared++;
    if (Wave !== '0) begin mismatched++; $display("FAIL midreset_wave got=%h want=0", Wave); end
    compared++;
    if (Sweep !== 1'b0) begin mismatched++; $display("FAIL midreset_sweep got=%b want=0", Sweep); end
    @(negedge Clk);
    nReset = 1'b1;
    cnt = 0;
    do begin
      @(posedge Clk);
      @(negedge Clk);
      cnt++;
      if (cnt == 3) begin
        compared++;
        if (Wave[17:0] !== 18'h0FFE0) begin mismatched++; $display("FAIL midreset_ch0 got=%h want=0ffe0", Wave[17:0]); end
        compared++;
        if (Wave[35:18] !== 18'h0) begin mismatched++; $display("FAIL midreset_ch1 got=%h want=0", Wave[35:18]); end
      end
    end while (!Sweep && cnt < 200);
    compared++;
    if (cnt != 36) begin mismatched++; $display("FAIL midreset_sweep_delay got=%0d want=36", cnt); end
  endtask

  initial begin
    test_reset;
    test_shape;
    test_latency;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
